// File: rtl/if_fetch_pkg.sv
// Shared definitions for the GeMIPS instruction-fetch front end.
package if_fetch_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INST  = 32'h0000_0000;
  localparam logic [31:0] INST_STEP = 32'd4;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register that catches a fetched instruction while IF/ID is stalled.
module if_skid_buf
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        flush,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  // A load in the same cycle as an unload refills the entry
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= 1'b0;
      pc    <= 32'h0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      inst  <= load_inst;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// IF-stage fetch front end: PC, single-outstanding imem port, skid and IF/ID output register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  redirect_pc;
  logic [31:0]  target_aligned;
  logic         ack_accept;
  logic         skid_valid;
  logic [31:0]  skid_pc;
  logic [31:0]  skid_inst;
  logic         skid_load;
  logic         skid_unload;

  assign target_aligned = branch_target & ~32'h3;
  assign imem_req  = !rst && (state == S_DRAIN || (state == S_FETCH && !skid_valid));
  assign imem_addr = fetch_pc;
  assign ack_accept = imem_req && imem_ack && (state == S_FETCH);

  assign skid_load   = !branch_flag && ack_accept && (stall || skid_valid);
  assign skid_unload = !branch_flag && !stall && skid_valid;

  if_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .flush    (branch_flag),
    .load_pc  (fetch_pc),
    .load_inst(imem_rdata),
    .valid    (skid_valid),
    .pc       (skid_pc),
    .inst     (skid_inst)
  );

  // A redirect outranks stall; in S_DRAIN the old response is swallowed before refetching
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      redirect_pc <= RESET_PC;
      state       <= S_FETCH;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_inst     <= NOP_INST;
    end else if (branch_flag) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
      if (state == S_DRAIN) begin
        if (imem_ack) begin
          fetch_pc <= target_aligned;
          state    <= S_FETCH;
        end else begin
          redirect_pc <= target_aligned;
        end
      end else if (imem_req && !imem_ack) begin
        redirect_pc <= target_aligned;
        state       <= S_DRAIN;
      end else begin
        fetch_pc <= target_aligned;
      end
    end else begin
      if (state == S_DRAIN) begin
        if (imem_ack) begin
          fetch_pc <= redirect_pc;
          state    <= S_FETCH;
        end
      end else if (ack_accept) begin
        fetch_pc <= fetch_pc + INST_STEP;
      end

      if (!stall) begin
        if (skid_valid) begin
          if_valid <= 1'b1;
          if_pc    <= skid_pc;
          if_inst  <= skid_inst;
        end else if (ack_accept) begin
          if_valid <= 1'b1;
          if_pc    <= fetch_pc;
          if_inst  <= imem_rdata;
        end else begin
          if_valid <= 1'b0;
          if_pc    <= 32'h0;
          if_inst  <= NOP_INST;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Randomized self-checking bench for if_fetch against a queue-based instruction-stream model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_valid     (if_valid)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: fetched-but-not-presented instructions plus the IF/ID view
  entry_t      pending[$];
  logic [31:0] mPc;
  logic        mDrain;
  logic [31:0] mRedir;
  logic        mValid;
  logic [31:0] mOutPc;
  logic [31:0] mOutInst;

  // Memory responder state
  int  waitMin = 0;
  int  waitMax = 0;
  bit  outstanding = 1'b0;
  int  waitLeft = 0;

  function automatic logic [31:0] instOf(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    pending.delete();
    mPc      = 32'h0;
    mDrain   = 1'b0;
    mRedir   = 32'h0;
    mValid   = 1'b0;
    mOutPc   = 32'h0;
    mOutInst = 32'h0;
  endtask

  // Called at a negedge: check current outputs, drive the next cycle, advance the model
  task automatic applyStimulus(input logic doStall, input logic doBranch,
                               input logic [31:0] tgt, input logic doReset);
    logic        expReq;
    logic        ack;
    logic [31:0] data;
    logic [31:0] tgtA;
    entry_t      e;

    expReq = !rst && (mDrain || pending.size() == 0);
    checkOutput("imem_req", {31'h0, imem_req}, {31'h0, expReq});
    if (expReq) checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("if_valid", {31'h0, if_valid}, {31'h0, mValid});
    checkOutput("if_pc", if_pc, mOutPc);
    checkOutput("if_inst", if_inst, mOutInst);

    ack  = 1'b0;
    data = $urandom;
    if (imem_req) begin
      if (!outstanding) begin
        outstanding = 1'b1;
        waitLeft = $urandom_range(waitMax, waitMin);
      end
      if (waitLeft == 0) begin
        ack = 1'b1;
        outstanding = 1'b0;
        data = mDrain ? 32'hDEAD_BEEF : instOf(imem_addr);
      end else begin
        waitLeft--;
      end
    end

    rst           = doReset;
    stall         = doStall;
    branch_flag   = doBranch;
    branch_target = tgt;
    imem_ack      = ack;
    imem_rdata    = data;

    tgtA = {tgt[31:2], 2'b00};
    if (doReset) begin
      outstanding = 1'b0;
      modelReset();
    end else if (doBranch) begin
      pending.delete();
      mValid = 1'b0; mOutPc = 32'h0; mOutInst = 32'h0;
      if (mDrain) begin
        if (ack) begin mPc = tgtA; mDrain = 1'b0; end
        else mRedir = tgtA;
      end else if (expReq && !ack) begin
        mDrain = 1'b1; mRedir = tgtA;
      end else begin
        mPc = tgtA;
      end
    end else begin
      if (mDrain) begin
        if (ack) begin mPc = mRedir; mDrain = 1'b0; end
      end else if (expReq && ack) begin
        pending.push_back({mPc, data});
        mPc = mPc + 32'd4;
      end
      if (!doStall) begin
        if (pending.size() > 0) begin
          e = pending.pop_front();
          mValid = 1'b1; mOutPc = e.pc; mOutInst = e.inst;
        end else begin
          mValid = 1'b0; mOutPc = 32'h0; mOutInst = 32'h0;
        end
      end
    end

    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        rs, rb;
    logic [31:0] rt;

    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    modelReset();
    @(posedge clk);
    @(negedge clk);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    waitMin = 2; waitMax = 2;
    repeat (15) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    waitMin = 0; waitMax = 0;
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    // Redirect while the skid is full, so no request is pending
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    waitMin = 3; waitMax = 3;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b0);
    repeat (12) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    waitMin = 0; waitMax = 0;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF4, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (5) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

    waitMin = 0; waitMax = 3;
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom % 4) == 0;
      rb = ($urandom % 12) == 0;
      rt = (($urandom % 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (($urandom % 300) == 0) begin
        applyStimulus(rs, 1'b0, 32'h0, 1'b1);
        applyStimulus(rs, 1'b0, 32'h0, 1'b0);
      end else begin
        applyStimulus(rs, rb, rt, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
